priority_dec: RTL and testbench
===============================

# priority_dec

Registered 2-to-4 priority decoder: the receive-side counterpart of the team's `priority_enc`. It accepts the encoder's `(Y, valid)` stream, buffers codes in a small FIFO and replays each code as a one-hot line on `D`. Each line is held for a programmable number of cycles. It sits downstream of `priority_enc` and drives per-line service strobes.

## Interface
- `HOLD_CYCLES`, default 2: cycles each decoded line stays asserted; legal range 1..15.
- `FIFO_DEPTH`, default 2: input buffer entries; power of two, 2..8.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `Y` in 2: encoded line index, with the same mapping as the encoder (00→D[3], 01→D[2], 10→D[1], 11→D[0]).
- `valid` in 1: `Y` is valid this cycle.
- `ready` out 1: the decoder can accept a code; a transfer occurs on a rising edge where `valid && ready`.
- `D` out 4: registered one-hot decoded output; 0000 when idle.
- `D_valid` out 1: registered; high exactly while `D` is non-zero.
- `overflow` out 1: sticky; set if `valid` is high while `ready` is low; cleared only by `rst`.

## Operation
- Reset (while `rst` is high, and on the first edge after it):
  - `D`=0000, `D_valid`=0, `overflow`=0.
  - FIFO empty, FSM in IDLE, hold counter 0.
  - `ready` is forced to 0 while `rst` is high.
- Input side:
  - `ready = !fifo_full && !rst`, combinational from registered state.
  - There is no pass-through: a push is accepted only when the FIFO is not full, even if a pop happens in the same cycle.
- Decode function: `D = 4'b1000 >> Y`.
- FSM states are IDLE and HOLD.
  - IDLE, FIFO empty: stay in IDLE; `D`=0, `D_valid`=0.
  - IDLE, FIFO non-empty: pop the head; load `D` with its one-hot value; set `D_valid`=1; load the counter with `HOLD_CYCLES-1`; go to HOLD.
  - HOLD, counter ≠ 0: decrement; `D` is unchanged.
  - HOLD, counter = 0, FIFO non-empty: pop the next code; load the new `D` and counter; stay in HOLD. This is back-to-back with no gap cycle.
  - HOLD, counter = 0, FIFO empty: `D`=0, `D_valid`=0; go to IDLE.
- Simultaneous push and pop: both occur. Occupancy is unchanged and FIFO order is preserved.
- The same code twice in a row produces continuous assertion of the same line for `2*HOLD_CYCLES` cycles, with no glitch low.
- Overflow: the rejected code is dropped, `overflow` sets, and FIFO contents are untouched.
- Reset mid-hold: `D` clears on the reset edge; queued codes are discarded.

## Timing
- Latency: a code transferred on edge k into an empty FIFO while in IDLE drives `D` after edge k+1.
- Each code holds `D` for exactly `HOLD_CYCLES` clock cycles.
- Throughput: one code per `HOLD_CYCLES` cycles, sustained.
- `ready` drops the cycle after the FIFO reaches `FIFO_DEPTH` entries. It rises the cycle after a pop from full.
- The FIFO uses wrapping read/write pointers of width `$clog2(FIFO_DEPTH)`, plus a count register of width `$clog2(FIFO_DEPTH)+1`.
- All outputs come directly from registers, except `ready`.

## Structure
- Package `priority_pkg` holds:
  - `CODE_W`=2 and `LINE_W`=4.
  - `typedef enum logic {IDLE, HOLD} dec_state_t`.
  - Function `decode_onehot(logic [1:0])`.
  - The encoder may share these.
- One sub-module: `priority_dec_fifo`, a synchronous FIFO with push, pop, full, empty, data and count.
- The top level holds the FSM, the hold counter and the `overflow` flag.

## Test plan
- Reset with `rst`=1 for 2 cycles, `valid`=1, `Y`=01 → `D`=0000, `D_valid`=0, `ready`=0, `overflow`=0; the FIFO is still empty after release.
- Single code, `HOLD_CYCLES`=2: `Y`=00 accepted on edge k → `D`=1000 during cycles k+1..k+2, then 0000 with `D_valid`=0.
- Back-to-back codes 01, 10, 11 sent as fast as `ready` allows → `D` goes 0100, 0010, 0001, each for 2 cycles, with no 0000 gap between them.
- Fill: 4 consecutive `valid` cycles with codes 00, 01, 10, 11 while the first is held, `FIFO_DEPTH`=2 → `ready` drops; the 4th code is dropped and `overflow`=1; only 1000, 0100, 0010 are output.
- Repeat code 11 twice → `D`=0001 held for 4 consecutive cycles.
- Assert `rst` while `D`=0010 with 1 code queued → `D`=0000 after the reset edge; no further output after release.

Source files
------------

// File: rtl/priority_pkg.sv
// Shared definitions for the priority encoder/decoder pair.
package priority_pkg;

  localparam int CODE_W = 2;
  localparam int LINE_W = 4;

  typedef enum logic {IDLE, HOLD} dec_state_t;

  // Code 0 selects the most significant line, matching the encoder's priority order.
  function automatic logic [LINE_W-1:0] decode_onehot(input logic [CODE_W-1:0] code);
    logic [LINE_W-1:0] top_line;
    top_line = {1'b1, {(LINE_W-1){1'b0}}};
    return top_line >> code;
  endfunction

endpackage

// File: rtl/priority_dec_if.sv
// Code stream handshake between priority_enc (master) and priority_dec (slave).
interface priority_dec_if;
  import priority_pkg::*;

  logic [CODE_W-1:0] Y;
  logic              valid;
  logic              ready;

  modport master (output Y, output valid, input ready);
  modport slave  (input Y, input valid, output ready);

endinterface

// File: rtl/priority_dec_fifo.sv
// Small synchronous FIFO buffering incoming codes; head entry is readable without a pop.
module priority_dec_fifo
  import priority_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = CODE_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE   = 1;
  localparam logic [PTR_W:0]   CNT_ONE   = 1;
  localparam logic [PTR_W:0]   CNT_FULL  = DEPTH[PTR_W:0];

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             do_push;
  logic             do_pop;

  assign full     = (count_reg == CNT_FULL);
  assign empty    = (count_reg == '0);
  assign count    = count_reg;
  assign pop_data = mem_reg[rd_ptr_reg];

  // Push is refused when full even if a pop happens in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_reg[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_ONE;
        2'b01:   count_reg <= count_reg - CNT_ONE;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/priority_dec.sv
// Registered 2-to-4 priority decoder: buffers encoder codes and replays each
// as a one-hot line held for HOLD_CYCLES cycles.
module priority_dec
  import priority_pkg::*;
#(
  parameter int HOLD_CYCLES = 2,
  parameter int FIFO_DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  priority_dec_if.slave     bus,
  output logic [LINE_W-1:0] D,
  output logic              D_valid,
  output logic              overflow
);

  localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);

  logic                        fifo_full;
  logic                        fifo_empty;
  logic [CODE_W-1:0]           fifo_data;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                        count_unused;
  logic                        push;
  logic                        pop;

  dec_state_t        state_reg;
  logic [3:0]        hold_cnt_reg;
  logic [LINE_W-1:0] d_reg;
  logic              d_valid_reg;
  logic              overflow_reg;

  assign bus.ready    = !fifo_full && !rst;
  assign push         = bus.valid && bus.ready;
  // A new code is taken whenever the output slot is free: idle, or the last hold cycle.
  assign pop          = !fifo_empty && ((state_reg == IDLE) || (hold_cnt_reg == '0));
  assign count_unused = ^fifo_count;

  priority_dec_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CODE_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (bus.Y),
    .pop       (pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      hold_cnt_reg <= '0;
      d_reg        <= '0;
      d_valid_reg  <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      if (bus.valid && !bus.ready) begin
        overflow_reg <= 1'b1;
      end
      case (state_reg)
        IDLE: begin
          if (pop) begin
            d_reg        <= decode_onehot(fifo_data);
            d_valid_reg  <= 1'b1;
            hold_cnt_reg <= HOLD_LOAD;
            state_reg    <= HOLD;
          end
        end
        HOLD: begin
          if (hold_cnt_reg != '0) begin
            hold_cnt_reg <= hold_cnt_reg - 4'd1;
          end else if (pop) begin
            d_reg        <= decode_onehot(fifo_data);
            hold_cnt_reg <= HOLD_LOAD;
          end else begin
            d_reg       <= '0;
            d_valid_reg <= 1'b0;
            state_reg   <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign D        = d_reg;
  assign D_valid  = d_valid_reg;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_priority_dec.sv
// Directed-vector bench for priority_dec with HOLD_CYCLES=2, FIFO_DEPTH=2.
module tb_priority_dec;
  import priority_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] d;
  logic       d_valid;
  logic       overflow;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  priority_dec_if bus_if ();

  priority_dec #(
    .HOLD_CYCLES (2),
    .FIFO_DEPTH  (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus_if.slave),
    .D        (d),
    .D_valid  (d_valid),
    .overflow (overflow)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Apply inputs, take one rising edge, then compare all outputs 1 time unit later.
  task automatic step(input string tag, input logic v, input logic [1:0] y,
                      input logic [3:0] d_exp, input logic rdy_exp, input logic ovf_exp);
    bus_if.valid = v;
    bus_if.Y     = y;
    @(posedge clk);
    #1;
    $display("%s: rst=%0b valid=%0b Y=%b -> D=%b D_valid=%0b ready=%0b overflow=%0b",
             tag, rst, v, y, d, d_valid, bus_if.ready, overflow);
    check_eq({tag, ".D"}, 32'(d), 32'(d_exp));
    check_eq({tag, ".D_valid"}, 32'(d_valid), 32'(d_exp != 4'b0000));
    check_eq({tag, ".ready"}, 32'(bus_if.ready), 32'(rdy_exp));
    check_eq({tag, ".overflow"}, 32'(overflow), 32'(ovf_exp));
  endtask

  initial begin
    rst          = 1'b1;
    bus_if.valid = 1'b1;
    bus_if.Y     = 2'b01;

    // Reset held 2 cycles with a valid code presented: nothing is accepted.
    step("rst0", 1'b1, 2'b01, 4'b0000, 1'b0, 1'b0);
    step("rst1", 1'b1, 2'b01, 4'b0000, 1'b0, 1'b0);
    rst = 1'b0;
    step("idle0", 1'b0, 2'b00, 4'b0000, 1'b1, 1'b0);
    step("idle1", 1'b0, 2'b00, 4'b0000, 1'b1, 1'b0);

    // Single code 00.
    step("single0", 1'b1, 2'b00, 4'b0000, 1'b1, 1'b0);
    step("single1", 1'b0, 2'b00, 4'b1000, 1'b1, 1'b0);
    step("single2", 1'b0, 2'b00, 4'b1000, 1'b1, 1'b0);
    step("single3", 1'b0, 2'b00, 4'b0000, 1'b1, 1'b0);

    // Back-to-back 01, 10, 11 as fast as ready allows.
    step("b2b0", 1'b1, 2'b01, 4'b0000, 1'b1, 1'b0);
    step("b2b1", 1'b1, 2'b10, 4'b0100, 1'b1, 1'b0);
    step("b2b2", 1'b1, 2'b11, 4'b0100, 1'b0, 1'b0);
    step("b2b3", 1'b0, 2'b00, 4'b0010, 1'b1, 1'b0);
    step("b2b4", 1'b0, 2'b00, 4'b0010, 1'b1, 1'b0);
    step("b2b5", 1'b0, 2'b00, 4'b0001, 1'b1, 1'b0);
    step("b2b6", 1'b0, 2'b00, 4'b0001, 1'b1, 1'b0);
    step("b2b7", 1'b0, 2'b00, 4'b0000, 1'b1, 1'b0);

    // Repeated code 11: line 0 high for 4 consecutive cycles.
    step("rep0", 1'b1, 2'b11, 4'b0000, 1'b1, 1'b0);
    step("rep1", 1'b1, 2'b11, 4'b0001, 1'b1, 1'b0);
    step("rep2", 1'b0, 2'b00, 4'b0001, 1'b1, 1'b0);
    step("rep3", 1'b0, 2'b00, 4'b0001, 1'b1, 1'b0);
    step("rep4", 1'b0, 2'b00, 4'b0001, 1'b1, 1'b0);
    step("rep5", 1'b0, 2'b00, 4'b0000, 1'b1, 1'b0);

    // Fill: fourth code arrives while full, is dropped and sets overflow.
    step("fill0", 1'b1, 2'b00, 4'b0000, 1'b1, 1'b0);
    step("fill1", 1'b1, 2'b01, 4'b1000, 1'b1, 1'b0);
    step("fill2", 1'b1, 2'b10, 4'b1000, 1'b0, 1'b0);
    step("fill3", 1'b1, 2'b11, 4'b0100, 1'b1, 1'b1);
    step("fill4", 1'b0, 2'b00, 4'b0100, 1'b1, 1'b1);
    step("fill5", 1'b0, 2'b00, 4'b0010, 1'b1, 1'b1);
    step("fill6", 1'b0, 2'b00, 4'b0010, 1'b1, 1'b1);
    step("fill7", 1'b0, 2'b00, 4'b0000, 1'b1, 1'b1);
    step("fill8", 1'b0, 2'b00, 4'b0000, 1'b1, 1'b1);

    // Reset while D=0010 with code 11 still queued.
    step("mid0", 1'b1, 2'b01, 4'b0000, 1'b1, 1'b1);
    step("mid1", 1'b1, 2'b10, 4'b0100, 1'b1, 1'b1);
    step("mid2", 1'b1, 2'b11, 4'b0100, 1'b0, 1'b1);
    step("mid3", 1'b0, 2'b00, 4'b0010, 1'b1, 1'b1);
    rst = 1'b1;
    step("mid_rst", 1'b0, 2'b00, 4'b0000, 1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step($sformatf("after_rst%0d", i), 1'b0, 2'b00, 4'b0000, 1'b1, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
